// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MDU_MADD_EN to implement the madd/maddu/msub/msubu accumulate ops.
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MTHI  = 4'd4;
   localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd6;
   localparam logic [3:0] OP_MADDU = 4'd7;
   localparam logic [3:0] OP_MSUB  = 4'd8;
   localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

   logic [3:0]  count_reg;
   logic [63:0] pend_reg;
   logic        commit_reg;
   logic [31:0] hi_reg;
   logic [31:0] lo_reg;

   logic [63:0] prod_s, prod_u, res_next;
   logic [31:0] abs_a, abs_b, div_b, uq, ur, quot, rem;
   logic        signed_div, a_neg, b_neg, div_zero, is_arith;
   logic [3:0]  lat_next;

   // Full-width products; both operands extended explicitly to 64 bits.
   always_comb begin
      prod_s = $unsigned($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
      prod_u = {32'd0, a} * {32'd0, b};
   end

   // Signed divide via magnitudes: quotient truncates toward zero, remainder
   // follows the dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0.
   always_comb begin
      signed_div = (op == OP_DIV);
      a_neg      = signed_div & a[31];
      b_neg      = signed_div & b[31];
      abs_a      = a_neg ? (32'd0 - a) : a;
      abs_b      = b_neg ? (32'd0 - b) : b;
      div_zero   = (b == 32'd0);
      div_b      = div_zero ? 32'd1 : abs_b;
      uq         = abs_a / div_b;
      ur         = abs_a % div_b;
      quot       = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
      rem        = a_neg ? (32'd0 - ur) : ur;
   end

   always_comb begin
      res_next = 64'd0;
      lat_next = 4'd0;
      is_arith = 1'b0;
      case (op)
         OP_MULT:  begin res_next = prod_s;      lat_next = 4'(MULT_CYCLES); is_arith = 1'b1; end
         OP_MULTU: begin res_next = prod_u;      lat_next = 4'(MULT_CYCLES); is_arith = 1'b1; end
         OP_DIV,
         OP_DIVU:  begin res_next = {rem, quot}; lat_next = 4'(DIV_CYCLES);  is_arith = 1'b1; end
`ifdef MDU_MADD_EN
         OP_MADD:  begin res_next = {hi_reg, lo_reg} + prod_s; lat_next = 4'(MULT_CYCLES); is_arith = 1'b1; end
         OP_MADDU: begin res_next = {hi_reg, lo_reg} + prod_u; lat_next = 4'(MULT_CYCLES); is_arith = 1'b1; end
         OP_MSUB:  begin res_next = {hi_reg, lo_reg} - prod_s; lat_next = 4'(MULT_CYCLES); is_arith = 1'b1; end
         OP_MSUBU: begin res_next = {hi_reg, lo_reg} - prod_u; lat_next = 4'(MULT_CYCLES); is_arith = 1'b1; end
`endif
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_reg  <= 4'd0;
         pend_reg   <= 64'd0;
         commit_reg <= 1'b0;
         hi_reg     <= 32'd0;
         lo_reg     <= 32'd0;
      end else if (count_reg != 4'd0) begin
         count_reg <= count_reg - 4'd1;
         if (count_reg == 4'd1 && commit_reg) begin
            hi_reg <= pend_reg[63:32];
            lo_reg <= pend_reg[31:0];
         end
      end else if (start) begin
         if (op == OP_MTHI) begin
            hi_reg <= a;
         end else if (op == OP_MTLO) begin
            lo_reg <= a;
         end else if (is_arith) begin
            count_reg <= lat_next;
            pend_reg  <= res_next;
            // A divide by zero still occupies the unit but never commits.
            commit_reg <= !((op == OP_DIV || op == OP_DIVU) && div_zero);
         end
      end
   end

   assign busy = (count_reg != 4'd0);
   assign hi   = hi_reg;
   assign lo   = lo_reg;

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the E stage of the pipelined MIPS core. Accepts one operation per start pulse, holds `busy` for a fixed multi-cycle latency, and commits results into architectural HI/LO registers. `hi` and `lo` feed the E-stage 32-bit result select mux, which implements mfhi/mflo. The hazard unit stalls D on `busy` or `start`.

## Interface
- `MULT_CYCLES`, 5, busy cycles for mult/multu and the madd family (legal range 1..15)
- `DIV_CYCLES`, 10, busy cycles for div/divu (legal range 1..15)

- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle request; sampled only when `busy`=0
- `op`  in  4  operation code:
  - 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo
  - 6 madd, 7 maddu, 8 msub, 9 msubu
  - all other codes are no-op
- `a`  in  32  rs operand
- `b`  in  32  rt operand
- `busy`  out  1  operation in flight
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- Reset (async assert, release on any edge): `hi`=0, `lo`=0, `busy`=0, counter=0, pending result cleared. Asserting reset mid-operation aborts it and no commit occurs.
- Edge with `start`=1 and `busy`=0:
  - mthi: `hi`<=`a` at that edge; `busy` stays 0.
  - mtlo: `lo`<=`a` at that edge; `busy` stays 0.
  - Arithmetic ops: latch op and operands, load counter with `MULT_CYCLES` or `DIV_CYCLES`, register the 64-bit pending result.
- `start` while `busy`=1: ignored. No-op codes: ignored, `busy` stays 0.
- `busy` = (counter != 0). Counter decrements each edge. On the edge where it goes 1→0, the pending {hi,lo} is written to `hi`/`lo`.
- Multiply (mult/multu): signed or unsigned 32×32→64; `hi`=upper word, `lo`=lower word.
- Divide (div/divu): `lo`=quotient, `hi`=remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
  - Divide by zero: `busy` runs the full `DIV_CYCLES`, then `hi`/`lo` stay unchanged (no commit).
- madd family: {hi,lo} ± product, modulo 2^64. The accumulator base is the {hi,lo} value at the start edge.

## Timing
- Start edge E0: `busy`=1 from E0 through the edge E0+N, where N is the latency parameter.
- New `hi`/`lo` are visible in the same cycle `busy` returns to 0. Back-to-back start is legal on that cycle.
- mthi/mtlo take effect at the start edge and are readable the next cycle (latency 1, no busy).
- `hi`/`lo` do not change at any edge other than a commit, mthi/mtlo, or reset.

## Configuration
- `MDU_MADD_EN` defined: ops 6–9 are implemented as above.
- `MDU_MADD_EN` undefined: ops 6–9 are no-ops. No busy, no state change, and no accumulator datapath is synthesized.

## Test plan
- Reset release → `hi`=0, `lo`=0, `busy`=0. Assert `reset_n`=0 during a div → all outputs cleared immediately and no later commit.
- mult a=0xFFFFFFFF, b=2 → `busy` high for exactly 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE. Same operands with multu → `hi`=1, `lo`=0xFFFFFFFE.
- div a=-7 (0xFFFFFFF9), b=2 → after 10 cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. divu a=7, b=0 → `busy` for 10 cycles, then `hi`/`lo` unchanged.
- div 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- mthi a=0x12345678 → `hi` updates next cycle with `busy`=0. A second start with op=mult issued during a running div → ignored, and the div result commits on schedule.
- With `MDU_MADD_EN`: `hi`=0, `lo`=0xFFFFFFFF, then maddu a=1, b=1 → `hi`=1, `lo`=0 after 5 cycles. Without the macro → no busy, values unchanged.
